// File: rtl/data_memory_ctrl.sv
// Data memory controller: byte/half/word CPU loads and stores plus a little-endian byte-stream programmer.
// Define DMEM_MISALIGN_TRAP_EN to trap misaligned/reserved accesses (write suppressed, load returns 0, err pulse).
module data_memory_ctrl #(
  parameter int ADDR_WIDTH = 14,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req_valid,
  input  logic                  req_write,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [31:0]           address,
  input  logic [DATA_WIDTH-1:0] write_data,
  output logic [DATA_WIDTH-1:0] read_data,
  output logic                  rd_valid,
  output logic                  busy,
  input  logic                  prog_start,
  input  logic                  prog_byte_valid,
  input  logic [7:0]            prog_byte,
  input  logic                  prog_last,
  output logic                  prog_done,
  output logic                  err
);
  // state | meaning
  // RUN   | CPU owns the memory; loads and stores are serviced
  // PROG  | programmer owns the memory; bytes are packed into words
  // DONE  | one-cycle prog_done pulse, then back to RUN
  typedef enum logic [1:0] {
    S_RUN  = 2'd0,
    S_PROG = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  state_t                r_state;
  state_t                w_next_state;
  logic [31:0]           r_mem [DEPTH];
  logic [ADDR_WIDTH-1:0] r_prog_addr;
  logic [1:0]            r_byte_cnt;
  logic [31:0]           r_word_buf;
  logic [31:0]           r_read_data;
  logic                  r_rd_valid;
  logic                  r_err;

  logic                  w_busy;
  logic                  w_prog_done;
  logic                  w_req;
  logic                  w_bad;
  logic [1:0]            w_size;
  logic [ADDR_WIDTH-1:0] w_idx;
  logic [31:0]           w_rword;
  logic [7:0]            w_byte;
  logic [15:0]           w_half;
  logic [31:0]           w_load_data;
  logic [31:0]           w_st_data;
  logic [3:0]            w_st_strb;
  logic                  w_prog_byte;
  logic                  w_prog_flush;
  logic [31:0]           w_prog_word;
  logic                  w_we;
  logic [ADDR_WIDTH-1:0] w_waddr;
  logic [31:0]           w_wdata;
  logic [3:0]            w_wstrb;
  logic                  w_unused;

  // Upper address bits alias onto the same words.
  assign w_unused = ^address[31:ADDR_WIDTH+2];

  always_comb begin
    w_next_state = r_state;
    w_busy       = 1'b0;
    w_prog_done  = 1'b0;
    case (r_state)
      S_RUN: begin
        if (prog_start) w_next_state = S_PROG;
      end
      S_PROG: begin
        w_busy = 1'b1;
        if (prog_byte_valid && prog_last) w_next_state = S_DONE;
      end
      S_DONE: begin
        w_busy       = 1'b1;
        w_prog_done  = 1'b1;
        w_next_state = S_RUN;
      end
      default: w_next_state = S_RUN;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) r_state <= S_RUN;
    else       r_state <= w_next_state;
  end

  assign w_req = req_valid && (r_state == S_RUN);
  assign w_idx = address[ADDR_WIDTH+1:2];

`ifdef DMEM_MISALIGN_TRAP_EN
  assign w_bad = ((req_size == 2'b01) && address[0])
              || ((req_size == 2'b10) && (address[1:0] != 2'b00))
              || (req_size == 2'b11);
`else
  assign w_bad = 1'b0;
`endif

  assign w_size = (req_size == 2'b11) ? 2'b10 : req_size;

  // Store data is replicated across lanes; the strobe picks the addressed lane(s).
  always_comb begin
    w_st_data = write_data;
    w_st_strb = 4'b1111;
    case (w_size)
      2'b00: begin
        w_st_data = {4{write_data[7:0]}};
        w_st_strb = 4'b0001 << address[1:0];
      end
      2'b01: begin
        w_st_data = {2{write_data[15:0]}};
        w_st_strb = address[1] ? 4'b1100 : 4'b0011;
      end
      default: ;
    endcase
  end

  always_comb begin
    w_rword = r_mem[w_idx];
    w_byte  = w_rword[{address[1:0], 3'b000} +: 8];
    w_half  = address[1] ? w_rword[31:16] : w_rword[15:0];
    case (w_size)
      2'b00:   w_load_data = {{24{~req_unsigned & w_byte[7]}}, w_byte};
      2'b01:   w_load_data = {{16{~req_unsigned & w_half[15]}}, w_half};
      default: w_load_data = w_rword;
    endcase
    if (w_bad) w_load_data = '0;
  end

  // Word buffer is cleared after every flush, so unfilled lanes of a short final word read as zero.
  assign w_prog_word  = r_word_buf | ({24'd0, prog_byte} << {r_byte_cnt, 3'b000});
  assign w_prog_byte  = (r_state == S_PROG) && prog_byte_valid;
  assign w_prog_flush = w_prog_byte && ((r_byte_cnt == 2'd3) || prog_last);

  always_comb begin
    w_we    = 1'b0;
    w_waddr = w_idx;
    w_wdata = w_st_data;
    w_wstrb = w_st_strb;
    if (w_prog_flush) begin
      w_we    = 1'b1;
      w_waddr = r_prog_addr;
      w_wdata = w_prog_word;
      w_wstrb = 4'b1111;
    end else if (w_req && req_write && !w_bad) begin
      w_we = 1'b1;
    end
  end

  // Memory array has no reset so contents survive a reset.
  always_ff @(posedge clock) begin
    if (!reset && w_we) begin
      for (int i = 0; i < 4; i++) begin
        if (w_wstrb[i]) r_mem[w_waddr][8*i +: 8] <= w_wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_read_data <= '0;
      r_rd_valid  <= 1'b0;
      r_err       <= 1'b0;
      r_prog_addr <= '0;
      r_byte_cnt  <= '0;
      r_word_buf  <= '0;
    end else begin
      r_rd_valid <= w_req && !req_write;
      r_err      <= w_req && w_bad;
      if (w_req && !req_write) r_read_data <= w_load_data;

      if ((r_state == S_RUN) && prog_start) begin
        r_prog_addr <= '0;
        r_byte_cnt  <= '0;
        r_word_buf  <= '0;
      end else if (w_prog_flush) begin
        r_prog_addr <= r_prog_addr + ADDR_WIDTH'(1);
        r_byte_cnt  <= '0;
        r_word_buf  <= '0;
      end else if (w_prog_byte) begin
        r_byte_cnt  <= r_byte_cnt + 2'd1;
        r_word_buf  <= w_prog_word;
      end
    end
  end

  assign read_data = r_read_data;
  assign rd_valid  = r_rd_valid;
  assign err       = r_err;
  assign busy      = w_busy;
  assign prog_done = w_prog_done;

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Randomized bench for data_memory_ctrl against a word-array/byte-queue reference model.
// Expectations follow DMEM_MISALIGN_TRAP_EN when the bench is built with it.
module tb_data_memory_ctrl;
  localparam int AW    = 6;
  localparam int DEPTH = 2 ** AW;
`ifdef DMEM_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid, req_write, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] address, write_data, read_data;
  logic        rd_valid, busy, prog_start, prog_byte_valid, prog_last, prog_done, err;
  logic [7:0]  prog_byte;

  data_memory_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(32)) dut (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_write(req_write),
    .req_size(req_size), .req_unsigned(req_unsigned), .address(address),
    .write_data(write_data), .read_data(read_data), .rd_valid(rd_valid), .busy(busy),
    .prog_start(prog_start), .prog_byte_valid(prog_byte_valid), .prog_byte(prog_byte),
    .prog_last(prog_last), .prog_done(prog_done), .err(err)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;

  // reference model: 0 = CPU mode, 1 = programming, 2 = done pulse
  logic [31:0] m_mem [DEPTH];
  int          m_phase = 0;
  int          m_paddr = 0;
  logic [7:0]  m_q [$];
  logic [31:0] e_read_data = '0;
  logic        e_rd_valid = 1'b0, e_err = 1'b0, e_busy = 1'b0, e_done = 1'b0, e_chk_rd = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] load_val(input logic [31:0] w, input logic [31:0] a,
                                           input int sz, input bit uns);
    logic [31:0] v;
    if (sz == 0) begin
      v = (w >> (8 * (a % 4))) & 32'hFF;
      if (!uns && v[7]) v = v | 32'hFFFF_FF00;
    end else if (sz == 1) begin
      v = (w >> (16 * ((a / 2) % 2))) & 32'hFFFF;
      if (!uns && v[15]) v = v | 32'hFFFF_0000;
    end else begin
      v = w;
    end
    return v;
  endfunction

  function automatic logic [31:0] store_val(input logic [31:0] w, input logic [31:0] a,
                                            input int sz, input logic [31:0] d);
    logic [31:0] m;
    int sh;
    if (sz == 0) begin
      sh = 8 * int'(a % 4);
      m  = 32'hFF << sh;
    end else if (sz == 1) begin
      sh = 16 * int'((a / 2) % 2);
      m  = 32'hFFFF << sh;
    end else begin
      sh = 0;
      m  = 32'hFFFF_FFFF;
    end
    return (w & ~m) | ((d << sh) & m);
  endfunction

  // Model advances on each rising edge from the sampled inputs, then outputs are compared.
  always @(posedge clock) begin
    int sz, idx;
    bit bad;
    logic [31:0] w;
    if (reset) begin
      m_phase = 0;
      m_paddr = 0;
      m_q.delete();
      e_rd_valid = 1'b0; e_err = 1'b0; e_read_data = '0; e_chk_rd = 1'b1;
    end else begin
      e_rd_valid = 1'b0; e_err = 1'b0; e_chk_rd = 1'b0;
      if (m_phase == 0) begin
        if (req_valid) begin
          sz  = int'(req_size);
          idx = int'((address / 4) % DEPTH);
          bad = TRAP && ((sz == 1 && address % 2 != 0) || (sz == 2 && address % 4 != 0) || sz == 3);
          if (sz == 3) sz = 2;
          if (req_write && !bad) m_mem[idx] = store_val(m_mem[idx], address, sz, write_data);
          if (!req_write) begin
            e_rd_valid  = 1'b1;
            e_chk_rd    = 1'b1;
            e_read_data = bad ? 32'h0 : load_val(m_mem[idx], address, sz, req_unsigned);
          end
          e_err = bad;
        end
        if (prog_start) begin
          m_phase = 1;
          m_paddr = 0;
          m_q.delete();
        end
      end else if (m_phase == 1) begin
        if (prog_byte_valid) begin
          m_q.push_back(prog_byte);
          if (m_q.size() == 4 || prog_last) begin
            w = '0;
            foreach (m_q[i]) w = w | (32'(m_q[i]) << (8 * i));
            m_mem[m_paddr] = w;
            m_paddr = (m_paddr + 1) % DEPTH;
            m_q.delete();
          end
          if (prog_last) m_phase = 2;
        end
      end else begin
        m_phase = 0;
      end
    end
    e_busy = (m_phase != 0);
    e_done = (m_phase == 2);
    #1;
    chk("rd_valid", rd_valid, e_rd_valid);
    chk("busy", busy, e_busy);
    chk("prog_done", prog_done, e_done);
    chk("err", err, e_err);
    if (e_chk_rd) chk("read_data", read_data, e_read_data);
  end

  task automatic tick();
    @(negedge clock);
  endtask

  task automatic idle();
    req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
    address = '0; write_data = '0; prog_start = 1'b0; prog_byte_valid = 1'b0;
    prog_byte = '0; prog_last = 1'b0;
  endtask

  task automatic st(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] d);
    idle();
    req_valid = 1'b1; req_write = 1'b1; req_size = sz; address = a; write_data = d;
    tick();
  endtask

  task automatic ld(input logic [31:0] a, input logic [1:0] sz, input logic uns);
    idle();
    req_valid = 1'b1; req_size = sz; req_unsigned = uns; address = a;
    tick();
  endtask

  // Programming byte with junk CPU traffic and a stray prog_start that must both be ignored.
  task automatic pbyte(input logic [7:0] b, input logic last);
    idle();
    req_valid = 1'($urandom_range(0, 1)); req_write = 1'b1; req_size = 2'b10;
    address = $urandom; write_data = $urandom; prog_start = 1'($urandom_range(0, 1));
    prog_byte_valid = 1'b1; prog_byte = b; prog_last = last;
    tick();
  endtask

  task automatic wait_done(input string nm);
    int pulses = 0;
    for (int k = 0; k < 4; k++) begin
      if (prog_done === 1'b1) pulses++;
      idle();
      tick();
    end
    chk({nm, "_done_pulses"}, pulses, 1);
    chk({nm, "_busy_after"}, busy, 1'b0);
  endtask

  initial begin
    logic [7:0] wb [260];
    reset = 1'b1;
    idle();
    repeat (3) tick();
    chk("rst_busy", busy, 1'b0);
    chk("rst_rd_valid", rd_valid, 1'b0);
    chk("rst_read_data", read_data, 32'h0);
    chk("rst_err", err, 1'b0);
    chk("rst_prog_done", prog_done, 1'b0);
    reset = 1'b0;

    for (int i = 0; i < DEPTH; i++) st(32'(i * 4), 2'b10, $urandom);

    st(32'h10, 2'b10, 32'h8765_4321);
    ld(32'h13, 2'b00, 1'b0);
    chk("b_ld_rd_valid", rd_valid, 1'b1);
    chk("b_ld_model", e_read_data, 32'hFFFF_FF87);
    chk("b_ld_dut", read_data, 32'hFFFF_FF87);

    st(32'h20, 2'b10, 32'h1111_1111);
    st(32'h22, 2'b01, 32'h0000_BEEF);
    ld(32'h20, 2'b10, 1'b0);
    chk("h_st_model", e_read_data, 32'hBEEF_1111);
    chk("h_st_dut", read_data, 32'hBEEF_1111);

    ld(32'h21, 2'b10, 1'b0);
    chk("mis_rd_valid", rd_valid, 1'b1);
    chk("mis_read_data", read_data, TRAP ? 32'h0 : 32'hBEEF_1111);
    chk("mis_err", err, TRAP);
    idle();
    tick();
    chk("mis_err_clear", err, 1'b0);

    idle();
    prog_start = 1'b1;
    tick();
    chk("prog_busy", busy, 1'b1);
    for (int i = 1; i <= 5; i++) pbyte(8'(i), i == 5);
    wait_done("p5");
    ld(32'h0, 2'b10, 1'b0);
    chk("p5_word0", read_data, 32'h0403_0201);
    ld(32'h4, 2'b10, 1'b0);
    chk("p5_word1", read_data, 32'h0000_0005);

    idle();
    prog_start = 1'b1;
    tick();
    pbyte(8'hAA, 1'b0);
    pbyte(8'hBB, 1'b0);
    idle();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst_prog_busy", busy, 1'b0);
    ld(32'h0, 2'b10, 1'b0);
    chk("rst_prog_word0", read_data, 32'h0403_0201);

    // 258 bytes: the programming address wraps and word 0 becomes a two-byte tail.
    idle();
    prog_start = 1'b1;
    tick();
    for (int i = 0; i < 258; i++) begin
      wb[i] = 8'($urandom);
      pbyte(wb[i], i == 257);
    end
    wait_done("wrap");
    ld(32'h0, 2'b10, 1'b1);
    chk("wrap_word0", read_data, {16'h0, wb[257], wb[256]});
    ld(32'h4, 2'b10, 1'b1);
    chk("wrap_word1", read_data, {wb[7], wb[6], wb[5], wb[4]});

    for (int c = 0; c < 3000; c++) begin
      reset           = ($urandom_range(0, 499) == 0);
      req_valid       = 1'($urandom_range(0, 1));
      req_write       = 1'($urandom_range(0, 1));
      req_size        = 2'($urandom_range(0, 3));
      req_unsigned    = 1'($urandom_range(0, 1));
      address         = $urandom;
      write_data      = $urandom;
      prog_start      = ($urandom_range(0, 149) == 0);
      prog_byte_valid = 1'($urandom_range(0, 1));
      prog_byte       = 8'($urandom);
      prog_last       = ($urandom_range(0, 39) == 0);
      tick();
    end
    reset = 1'b0;
    idle();
    repeat (4) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/data_memory_ctrl.md
DATA_MEMORY_CTRL -- requirements
Module: data_memory_ctrl

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 14, word-address bits; depth = 2**ADDR_WIDTH 32-bit words.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, word width; only 32 is supported.
REQ-003 SHALL have port clock  in  1  the single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  in  1  reset, synchronous, active-high.
REQ-005 SHALL have port req_valid  in  1  CPU access request this cycle.
REQ-006 SHALL have port req_write  in  1  1 = store, 0 = load.
REQ-007 SHALL have port req_size  in  2  00 byte, 01 half, 10 word, 11 reserved.
REQ-008 SHALL have port req_unsigned  in  1  1 = zero-extend loads, 0 = sign-extend.
REQ-009 SHALL have port address  in  32  byte address; bits above ADDR_WIDTH+1 ignored (aliasing).
REQ-010 SHALL have port write_data  in  32  store data, right-aligned.
REQ-011 SHALL have port read_data  out  32  extended load result.
REQ-012 SHALL have port rd_valid  out  1  read_data valid this cycle.
REQ-013 SHALL have port busy  out  1  high while the programmer owns the memory.
REQ-014 SHALL have port prog_start  in  1  begin a programming load.
REQ-015 SHALL have port prog_byte_valid  in  1  prog_byte is valid.
REQ-016 SHALL have port prog_byte  in  8  programming data byte.
REQ-017 SHALL have port prog_last  in  1  qualifies the final programming byte.
REQ-018 SHALL have port prog_done  out  1  one-cycle pulse at end of load.
REQ-019 SHALL have port err  out  1  misaligned/reserved access pulse.

Function
REQ-020 SHALL implement FSM states RUN, PROG, DONE; RUN after reset.
REQ-021 In RUN, a load (req_valid & !req_write) SHALL assert rd_valid with read_data exactly one cycle later.
REQ-022 Load result: byte lane address[1:0] / half lane address[1] / full word, extended per req_unsigned captured with the request.
REQ-023 Stores SHALL write only the addressed lanes: byte -> write_data[7:0], half -> write_data[15:0], word -> all 32 bits.
REQ-024 A load in cycle N+1 to a word stored in cycle N SHALL return the newly stored data.
REQ-025 busy SHALL be 1 in PROG and DONE; req_valid SHALL be ignored there (no write, no rd_valid).
REQ-026 RUN -> PROG on prog_start; word address and byte counter cleared to 0.
REQ-027 In PROG each prog_byte_valid SHALL place prog_byte into lane byte_count, little-endian (first byte -> bits 7:0).
REQ-028 On the 4th byte the assembled word SHALL be written at the programming address, address incremented, byte_count cleared.
REQ-029 prog_byte_valid & prog_last SHALL write the word with unfilled lanes zero, then go to DONE.
REQ-030 The programming address SHALL wrap from 2**ADDR_WIDTH-1 to 0.
REQ-031 DONE SHALL assert prog_done for exactly one cycle, then return to RUN.
REQ-032 prog_start in PROG or DONE SHALL be ignored.

Reset
REQ-033 Reset SHALL force state RUN; read_data 0; rd_valid, busy, prog_done, err 0; counters 0.
REQ-034 Reset SHALL NOT clear memory contents.
REQ-035 Reset mid-PROG SHALL discard the partial word and retain words already written.

Configuration
REQ-036 Macro DMEM_MISALIGN_TRAP_EN defined: half with address[0]=1, word with address[1:0]!=0, or size 11 SHALL suppress the write.
REQ-037 Under DMEM_MISALIGN_TRAP_EN, such a load SHALL give rd_valid with read_data 0, and err SHALL pulse one cycle after the offending request.
REQ-038 Macro undefined: misaligned low address bits SHALL be ignored, size 11 treated as word, err tied 0.

Verification
REQ-039 Word store 0x8765_4321 at 0x10, then signed byte load at 0x13 -> rd_valid next cycle, read_data 0xFFFF_FF87.
REQ-040 Half store 0xBEEF at 0x22 over word 0x1111_1111, then word load at 0x20 -> read_data 0xBEEF_1111.
REQ-041 prog_start, bytes 01 02 03 04 05 with last on 05 -> word0 0x0403_0201, word1 0x0000_0005, prog_done one pulse, busy back to 0.
REQ-042 Reset after 2 of 4 bytes in PROG -> state RUN, word0 unchanged, busy 0.
REQ-043 Misaligned word load at 0x21 with macro -> read_data 0, err 1 for one cycle; without macro -> read_data = word at 0x20, err 0.
